agemat_multi: RTL and testbench
===============================

Name: agemat_multi

Overview:
- Parametrised successor to the single-grant age matrix used by the scheduler and load/store queues.
- Tracks relative age of up to WIDTH entries and accepts up to INSERTS allocations per cycle.
- Issues up to GRANTS one-hot grants per cycle, ordered oldest-first, or youngest-first when OLDEST=0.
- Adds entry valid tracking, per-entry free, full flush and occupancy outputs, so a multi-issue select stage can use it directly.

Parameters:
- WIDTH, 16: number of tracked entries (2..64).
- INSERTS, 2: insert ports per cycle (1..4).
- GRANTS, 2: grant slots per cycle (1..4; GRANTS <= WIDTH).
- OLDEST, 1: 1 = slot 0 gets the oldest requester; 0 = slot 0 gets the youngest.
- CW, $clog2(WIDTH+1): width of the count output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- insert_valid  in  INSERTS  per-port insert strobe.
- insert_sel  in  INSERTS*WIDTH  per-port one-hot entry select; port p occupies bits [p*WIDTH +: WIDTH].
- free_sel  in  WIDTH  entries to deallocate this cycle.
- flush  in  1  deallocate all entries.
- req  in  WIDTH  request vector; masked internally by valid.
- grant_valid  out  GRANTS  slot g holds a grant.
- grant  out  GRANTS*WIDTH  slot g one-hot grant at [g*WIDTH +: WIDTH].
- valid  out  WIDTH  registered entry-valid mask.
- count  out  CW  number of valid entries (popcount of valid).
- full  out  1  count == WIDTH.

Behaviour:
- State:
  - Age matrix M[WIDTH][WIDTH]. M[i][j]=1 means entry i is older than entry j. The diagonal is ignored.
  - valid[WIDTH] register.
  - Both registers are cleared asynchronously on rst. After reset: valid=0, count=0, full=0, grant=0, grant_valid=0.
- Insert, port p with insert_valid[p]=1 and insert_sel bit i:
  - At the next clk edge: valid[i]<=1.
  - For every j != i: M[j][i]<=1 and M[i][j]<=0, so i becomes younger than every other entry.
  - Several ports in one cycle: a lower port index is older. For ports p<q on entries a and b, the result is M[a][b]=1 and M[b][a]=0.
  - Inserting an already-valid entry is legal. It is reallocated as youngest with no error flag.
- Free: free_sel[i]=1 clears valid[i] at the next edge. M is not modified for freed entries.
- Same-cycle precedence, per entry: insert > flush > free.
  - flush clears valid for every entry not inserted this cycle.
  - An entry both inserted and freed in the same cycle ends valid and youngest.
- Grant selection is combinational from the current registered state and req.
  - Zero latency: an entry inserted at edge t is grantable in the cycle after t, not in the cycle of the insert.
  - eff = req & valid.
  - For each requesting entry i, rank(i) = the number of requesting entries older than i (OLDEST=1) or younger than i (OLDEST=0).
  - Slot g grants the unique entry with rank g. grant_valid[g] = (popcount(eff) > g).
  - Unused slots drive all-zero grant.
  - No entry appears in two slots, and slots fill contiguously from 0.
- Grants do not free entries; the consumer must assert free_sel.
- count and full are derived from registered valid only. They reflect same-cycle inserts/frees at the next cycle.
- rst asserted mid-operation: all state clears immediately (asynchronously); the first insert after deassertion behaves as into an empty matrix.
- Boundaries:
  - A fully occupied matrix with more than GRANTS requesters grants only the GRANTS oldest.
  - WIDTH=2 and GRANTS=WIDTH must work.
- Implementation restriction: no combinational path from insert_* or free_sel to grant.

Test Plan:
- Reset, then inserts port0->e3, port1->e5 in one cycle, then e1 the next cycle. With req=0xFFFF: slot0=e3 (0x0008), slot1=e5 (0x0020), grant_valid=2'b11, count=3.
- Same state, req=0x0002 (only e1): slot0=0x0002, slot1=0, grant_valid=2'b01. Same state with req=0: grant_valid=0.
- Fill all 16 entries in order e0..e15, req=0xFFFF, then free e0 and e1: grants go e0,e1 before the free; e2,e3 the cycle after; full drops from 1 to 0; count=14.
- Re-insert valid entry e2 while e2..e15 are valid: the following cycle grants e3,e4; e2 is ranked last.
- OLDEST=0 build, inserts e0,e1,e2 in successive cycles, req=0x7: slot0=e2, slot1=e1.
- flush together with insert e7: the next cycle valid=0x0080, count=1. Assert rst asynchronously mid-cycle: valid=0 and grant_valid=0 before the next clk edge.

Source files
------------

// File: rtl/agemat_multi.sv
// agemat_multi: age matrix over WIDTH entries with INSERTS allocations and
// GRANTS oldest-first (or youngest-first) one-hot grants per cycle.
`default_nettype none

module agemat_multi #(
  parameter int WIDTH   = 16,
  parameter int INSERTS = 2,
  parameter int GRANTS  = 2,
  parameter int OLDEST  = 1,
  parameter int CW      = $clog2(WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INSERTS-1:0]        insert_valid,
  input  logic [INSERTS*WIDTH-1:0]  insert_sel,
  input  logic [WIDTH-1:0]          free_sel,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          req,
  output logic [GRANTS-1:0]         grant_valid,
  output logic [GRANTS*WIDTH-1:0]   grant,
  output logic [WIDTH-1:0]          valid,
  output logic [CW-1:0]             count,
  output logic                      full
);

  // age[i][j] = 1 means entry i is older than entry j
  logic [WIDTH-1:0] age     [WIDTH];
  logic [WIDTH-1:0] age_nxt [WIDTH];
  logic [WIDTH-1:0] valid_nxt;
  logic [WIDTH-1:0] eff;
  logic [CW-1:0]    rank    [WIDTH];
  logic [CW-1:0]    eff_cnt;

  // Ports are applied in index order so a higher port ends up younger.
  always_comb begin
    age_nxt   = age;
    valid_nxt = flush ? '0 : (valid & ~free_sel);
    for (int p = 0; p < INSERTS; p++) begin
      if (insert_valid[p]) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (insert_sel[p*WIDTH+i]) begin
            valid_nxt[i] = 1'b1;
            for (int j = 0; j < WIDTH; j++) begin
              if (j != i) begin
                age_nxt[j][i] = 1'b1;
                age_nxt[i][j] = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < WIDTH; i++) age[i] <= '0;
    end else begin
      valid <= valid_nxt;
      for (int i = 0; i < WIDTH; i++) age[i] <= age_nxt[i];
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(valid[i]);
    full = (count == CW'(WIDTH));
  end

  // Grants depend only on registered state and req.
  always_comb begin
    eff     = req & valid;
    eff_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eff_cnt = eff_cnt + CW'(eff[i]);
      rank[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j != i && eff[j] && ((OLDEST != 0) ? age[j][i] : age[i][j]))
          rank[i] = rank[i] + CW'(1);
      end
    end
    grant       = '0;
    grant_valid = '0;
    for (int g = 0; g < GRANTS; g++) begin
      grant_valid[g] = (eff_cnt > CW'(g));
      for (int i = 0; i < WIDTH; i++)
        grant[g*WIDTH+i] = eff[i] && (rank[i] == CW'(g));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_agemat_multi.sv
// Self-checking bench for agemat_multi: queue-based scoreboard against an age-list model.
`default_nettype none

module tb_agemat_multi;

  typedef int iq_t[$];
  typedef struct {
    logic [63:0] grant;
    logic [3:0]  gv;
    logic [63:0] valid;
    int          count;
    bit          full;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  insert_valid;
  logic [31:0] insert_sel;
  logic [15:0] free_sel, req;
  logic        flush;
  logic [1:0]  grant_valid;
  logic [31:0] grant;
  logic [15:0] valid;
  logic [4:0]  count;
  logic        full;

  logic [0:0]  y_insert_valid;
  logic [3:0]  y_insert_sel, y_free_sel, y_req;
  logic        y_flush;
  logic [3:0]  y_grant_valid;
  logic [15:0] y_grant;
  logic [3:0]  y_valid;
  logic [2:0]  y_count;
  logic        y_full;

  agemat_multi #(.WIDTH(16), .INSERTS(2), .GRANTS(2), .OLDEST(1)) dut (
    .clk(clk), .rst(rst), .insert_valid(insert_valid), .insert_sel(insert_sel),
    .free_sel(free_sel), .flush(flush), .req(req), .grant_valid(grant_valid),
    .grant(grant), .valid(valid), .count(count), .full(full));

  agemat_multi #(.WIDTH(4), .INSERTS(1), .GRANTS(4), .OLDEST(0)) dut_y (
    .clk(clk), .rst(rst), .insert_valid(y_insert_valid), .insert_sel(y_insert_sel),
    .free_sel(y_free_sel), .flush(y_flush), .req(y_req), .grant_valid(y_grant_valid),
    .grant(y_grant), .valid(y_valid), .count(y_count), .full(y_full));

  int n_checks = 0;
  int n_errors = 0;
  iq_t ord, yord;
  logic [63:0] mv, yv;
  exp_t sb[$], yb[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic iq_t bump(iq_t q, int e);
    iq_t r;
    foreach (q[i]) if (q[i] != e) r.push_back(q[i]);
    r.push_back(e);
    return r;
  endfunction

  task automatic grant_exp(input iq_t o, input logic [63:0] v, input logic [63:0] r,
                           input int w, input int g, input bit oldest,
                           output logic [63:0] gr, output logic [3:0] gv);
    int k, e;
    k = 0; gr = '0; gv = '0;
    for (int i = 0; i < o.size(); i++) begin
      e = oldest ? o[i] : o[o.size()-1-i];
      if (v[e] && r[e] && k < g) begin
        gr[k*w+e] = 1'b1;
        gv[k] = 1'b1;
        k++;
      end
    end
  endtask

  task automatic push_expected();
    exp_t e, ey;
    grant_exp(ord, mv, {48'b0, req}, 16, 2, 1'b1, e.grant, e.gv);
    e.valid = mv; e.count = $countones(mv); e.full = (e.count == 16);
    sb.push_back(e);
    grant_exp(yord, yv, {60'b0, y_req}, 4, 4, 1'b0, ey.grant, ey.gv);
    ey.valid = yv; ey.count = $countones(yv); ey.full = (ey.count == 4);
    yb.push_back(ey);
  endtask

  task automatic pop_compare();
    exp_t e, ey;
    e = sb.pop_front();
    check_eq("sb_grant", {32'b0, grant}, e.grant);
    check_eq("sb_gvalid", {62'b0, grant_valid}, {60'b0, e.gv});
    check_eq("sb_valid", {48'b0, valid}, e.valid);
    check_eq("sb_count", {59'b0, count}, 64'(e.count));
    check_eq("sb_full", {63'b0, full}, {63'b0, e.full});
    ey = yb.pop_front();
    check_eq("y_grant", {48'b0, y_grant}, ey.grant);
    check_eq("y_gvalid", {60'b0, y_grant_valid}, {60'b0, ey.gv});
    check_eq("y_valid", {60'b0, y_valid}, ey.valid);
    check_eq("y_count", {61'b0, y_count}, 64'(ey.count));
    check_eq("y_full", {63'b0, y_full}, {63'b0, ey.full});
  endtask

  task automatic model_update();
    logic [63:0] nv;
    nv = flush ? 64'b0 : (mv & ~{48'b0, free_sel});
    for (int p = 0; p < 2; p++)
      if (insert_valid[p])
        for (int i = 0; i < 16; i++)
          if (insert_sel[p*16+i]) begin nv[i] = 1'b1; ord = bump(ord, i); end
    mv = nv;
    nv = y_flush ? 64'b0 : (yv & ~{60'b0, y_free_sel});
    if (y_insert_valid[0])
      for (int i = 0; i < 4; i++)
        if (y_insert_sel[i]) begin nv[i] = 1'b1; yord = bump(yord, i); end
    yv = nv;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    #1 push_expected();
    #1 pop_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    insert_valid = '0; insert_sel = '0; free_sel = '0; flush = 1'b0;
    y_insert_valid = '0; y_insert_sel = '0; y_free_sel = '0; y_flush = 1'b0;
  endtask

  task automatic ins(input int p, input int e);
    insert_valid[p] = 1'b1;
    insert_sel[p*16 +: 16] = 16'h0001 << e;
  endtask

  task automatic y_ins(input int e);
    y_insert_valid = 1'b1;
    y_insert_sel = 4'h1 << e;
  endtask

  initial begin
    int e0;
    rst = 1'b1; idle(); req = '0; y_req = '0; mv = '0; yv = '0;
    @(negedge clk);
    req = 16'hFFFF; y_req = 4'hF;
    #1;
    check_eq("rst_valid", {48'b0, valid}, 64'h0);
    check_eq("rst_count", {59'b0, count}, 64'h0);
    check_eq("rst_full", {63'b0, full}, 64'h0);
    check_eq("rst_gvalid", {62'b0, grant_valid}, 64'h0);
    check_eq("rst_grant", {32'b0, grant}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Two same-cycle inserts, then a third
    idle(); req = '0; ins(0, 3); ins(1, 5); tick();
    idle(); ins(0, 1); tick();
    idle(); req = 16'hFFFF; #1;
    check_eq("t1_slot0", {48'b0, grant[15:0]}, 64'h0008);
    check_eq("t1_slot1", {48'b0, grant[31:16]}, 64'h0020);
    check_eq("t1_gvalid", {62'b0, grant_valid}, 64'h3);
    check_eq("t1_count", {59'b0, count}, 64'd3);
    tick();
    req = 16'h0002; #1;
    check_eq("t2_slot0", {48'b0, grant[15:0]}, 64'h0002);
    check_eq("t2_slot1", {48'b0, grant[31:16]}, 64'h0);
    check_eq("t2_gvalid", {62'b0, grant_valid}, 64'h1);
    tick();
    req = '0; #1;
    check_eq("t2_noreq", {62'b0, grant_valid}, 64'h0);
    tick();

    // Fill all entries, then free the two oldest
    idle(); flush = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      idle(); ins(0, 2*k); ins(1, 2*k+1); tick();
    end
    idle(); req = 16'hFFFF; #1;
    check_eq("fill_slot0", {48'b0, grant[15:0]}, 64'h0001);
    check_eq("fill_slot1", {48'b0, grant[31:16]}, 64'h0002);
    check_eq("fill_full", {63'b0, full}, 64'h1);
    check_eq("fill_count", {59'b0, count}, 64'd16);
    free_sel = 16'h0003; tick();
    idle(); #1;
    check_eq("free_slot0", {48'b0, grant[15:0]}, 64'h0004);
    check_eq("free_slot1", {48'b0, grant[31:16]}, 64'h0008);
    check_eq("free_full", {63'b0, full}, 64'h0);
    check_eq("free_count", {59'b0, count}, 64'd14);
    tick();

    // Re-insert an already valid entry
    idle(); ins(0, 2); tick();
    idle(); #1;
    check_eq("reins_slot0", {48'b0, grant[15:0]}, 64'h0008);
    check_eq("reins_slot1", {48'b0, grant[31:16]}, 64'h0010);
    tick();
    req = 16'h8004; #1;
    check_eq("reins_last0", {48'b0, grant[15:0]}, 64'h8000);
    check_eq("reins_last1", {48'b0, grant[31:16]}, 64'h0004);
    tick();

    // Flush with a simultaneous insert
    idle(); req = 16'hFFFF; flush = 1'b1; ins(0, 7); tick();
    idle(); #1;
    check_eq("flush_valid", {48'b0, valid}, 64'h0080);
    check_eq("flush_count", {59'b0, count}, 64'd1);
    tick();

    // Asynchronous reset in the middle of a cycle
    idle(); ins(0, 9); y_ins(1); tick();
    idle();
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", {48'b0, valid}, 64'h0);
    check_eq("arst_gvalid", {62'b0, grant_valid}, 64'h0);
    check_eq("arst_yvalid", {60'b0, y_valid}, 64'h0);
    mv = '0; ord = {}; yv = '0; yord = {};
    #1 rst = 1'b0;
    @(negedge clk);
    ins(0, 4); tick();
    idle(); #1;
    check_eq("post_rst_slot0", {48'b0, grant[15:0]}, 64'h0010);
    check_eq("post_rst_count", {59'b0, count}, 64'd1);
    tick();

    // Youngest-first instance
    idle(); y_ins(0); tick();
    idle(); y_ins(1); tick();
    idle(); y_ins(2); tick();
    idle(); y_req = 4'h7; #1;
    check_eq("young_slot0", {60'b0, y_grant[3:0]}, 64'h4);
    check_eq("young_slot1", {60'b0, y_grant[7:4]}, 64'h2);
    check_eq("young_slot2", {60'b0, y_grant[11:8]}, 64'h1);
    check_eq("young_slot3", {60'b0, y_grant[15:12]}, 64'h0);
    check_eq("young_gvalid", {60'b0, y_grant_valid}, 64'h7);
    tick();

    // Random traffic through the scoreboard
    repeat (400) begin
      idle();
      e0 = $urandom_range(0, 15);
      insert_valid = 2'($urandom);
      insert_sel = {16'h0001 << ((e0 + 1 + $urandom_range(0, 14)) % 16), 16'h0001 << e0};
      free_sel = 16'($urandom & $urandom & $urandom);
      flush = ($urandom_range(0, 31) == 0);
      req = 16'($urandom);
      y_insert_valid = 1'($urandom);
      y_insert_sel = 4'h1 << $urandom_range(0, 3);
      y_free_sel = 4'($urandom & $urandom);
      y_flush = ($urandom_range(0, 31) == 0);
      y_req = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
